// File: rtl/rrp_arbiter_burst.sv
// Round-robin merge of CHANNELS FWFT source FIFOs into one output stream.
// Supports a per-channel enable mask, a bounded burst per grant, packet hold, an optional channel tag and a word counter.
module rrp_arbiter_burst #(
    parameter int unsigned CHANNELS   = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_MAX  = 16,
    parameter int unsigned TAG_EN     = 0,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [CHANNELS-1:0]            EN_MASK,
    input  logic [CHANNELS-1:0]            WRITE_REQ,
    input  logic [CHANNELS-1:0]            HOLD_REQ,
    input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
    output logic [CHANNELS-1:0]            READ_GRANT,
    input  logic                           READY_OUT,
    output logic                           WRITE_OUT,
    output logic [DATA_WIDTH-1:0]          DATA_OUT,
    output logic [3:0]                     GRANT_ID,
    output logic [CNT_WIDTH-1:0]           WORD_CNT
);

    localparam int unsigned ID_W    = 4;
    localparam int unsigned MAX_CH  = 16;
    localparam int unsigned BURST_W = 8;

    localparam logic [ID_W-1:0]    LAST_INIT  = ID_W'(CHANNELS - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
    localparam logic [BURST_W-1:0] BURST_SAT  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       cur;
    logic [ID_W-1:0]       last;
    logic [BURST_W-1:0]    burst;

    logic [MAX_CH-1:0]     en_pad;
    logic [MAX_CH-1:0]     wreq_pad;
    logic [MAX_CH-1:0]     hold_pad;
    logic [MAX_CH-1:0]     req_pad;

    logic                  found;
    logic [ID_W-1:0]       next_idx;
    logic [ID_W-1:0]       cand;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DATA_WIDTH-1:0] out_word;
    logic                  pop;
    logic                  leave;

    // Pad channel vectors to the 4-bit index range so a channel index selects them directly.
    assign en_pad   = MAX_CH'(EN_MASK);
    assign wreq_pad = MAX_CH'(WRITE_REQ);
    assign hold_pad = MAX_CH'(HOLD_REQ);
    assign req_pad  = en_pad & wreq_pad;

    assign GRANT_ID = cur;

    // Rotating priority scan starting just after the last served channel.
    always_comb begin
        found    = 1'b0;
        next_idx = last;
        cand     = '0;
        for (int i = 1; i <= int'(CHANNELS); i++) begin
            cand = ID_W'((int'(last) + i) % int'(CHANNELS));
            if (!found && req_pad[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    // Source word of the granted channel, optionally tagged with its index.
    always_comb begin
        cur_data = '0;
        for (int j = 0; j < int'(CHANNELS); j++) begin
            if (cur == ID_W'(j)) begin
                cur_data = DATA_IN[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        out_word = cur_data;
        if (TAG_EN != 0) begin
            out_word[DATA_WIDTH-1 -: ID_W] = cur;
        end
    end

    // Reset gates the pop so an aborted burst never takes a word from its source.
    always_comb begin
        pop = (state == S_GRANT) && !BUS_RST && READY_OUT && req_pad[cur];
        READ_GRANT = '0;
        for (int j = 0; j < int'(CHANNELS); j++) begin
            READ_GRANT[j] = pop && (cur == ID_W'(j));
        end
    end

    // Mask removal beats hold; hold can carry the burst count past the limit, hence >=.
    always_comb begin
        leave = !en_pad[cur] ||
                (!hold_pad[cur] && ((pop && (burst >= BURST_LAST)) || !wreq_pad[cur]));
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= S_IDLE;
            cur       <= '0;
            last      <= LAST_INIT;
            burst     <= '0;
            WRITE_OUT <= 1'b0;
            DATA_OUT  <= '0;
            WORD_CNT  <= '0;
        end else begin
            WRITE_OUT <= pop;
            if (pop) begin
                DATA_OUT <= out_word;
                if (burst != BURST_SAT) begin
                    burst <= burst + BURST_W'(1);
                end
                if (WORD_CNT != CNT_SAT) begin
                    WORD_CNT <= WORD_CNT + CNT_WIDTH'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    if (found) begin
                        cur   <= next_idx;
                        burst <= '0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (leave) begin
                        last  <= cur;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
